dfd_entry_packer: RTL

//  Packs variable-count input beats (0..NUM_IN entries, left-justified) into dense NUM_OUT-entry lines.

---
 rtl/dfd_entry_packer_if.sv | 30 +++
 rtl/dfd_entry_packer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/dfd_entry_packer_if.sv
// Beat channel (producer -> packer) and line channel (packer -> consumer) of the entry packer.
// The packer uses the slave modport; the traffic source/sink uses master.
interface dfd_entry_packer_if #(
   parameter int NUM_IN    = 6,
   parameter int NUM_OUT   = 8,
   parameter int DATA_SIZE = 10
);
   localparam int CIW = $clog2(NUM_IN + 1);
   localparam int COW = $clog2(NUM_OUT + 1);

   logic                         in_valid;
   logic                         in_ready;
   logic [NUM_IN*DATA_SIZE-1:0]  in_data;
   logic [CIW-1:0]               in_count;
   logic                         in_flush;
   logic                         out_valid;
   logic                         out_ready;
   logic [NUM_OUT*DATA_SIZE-1:0] out_data;
   logic [COW-1:0]               out_count;

   modport master (
      output in_valid, in_data, in_count, in_flush, out_ready,
      input  in_ready, out_valid, out_data, out_count
   );

   modport slave (
      input  in_valid, in_data, in_count, in_flush, out_ready,
      output in_ready, out_valid, out_data, out_count
   );
endinterface

// File: rtl/dfd_entry_packer.sv
// Packs variable-count, left-justified input beats into dense NUM_OUT-entry lines,
// emitting full lines as they complete and a partial remainder on flush.
module dfd_entry_packer #(
   parameter int NUM_IN    = 6,
   parameter int NUM_OUT   = 8,
   parameter int DATA_SIZE = 10
) (
   input  logic              clk,
   input  logic              reset_n,
   dfd_entry_packer_if.slave bus
);
   localparam int CIW = $clog2(NUM_IN + 1);
   localparam int COW = $clog2(NUM_OUT + 1);
   localparam int FW  = $clog2(NUM_OUT);
   localparam int SW  = $clog2(2 * NUM_OUT);
   localparam int LW  = NUM_OUT * DATA_SIZE;

   typedef enum logic {ST_FILL, ST_FLUSH_PEND} state_t;

   state_t         state_q, state_d;
   logic [FW-1:0]  fill_q, fill_d;
   logic [LW-1:0]  staging_q, staging_d;
   logic           out_valid_q, out_valid_d;
   logic [LW-1:0]  out_data_q, out_data_d;
   logic [COW-1:0] out_count_q, out_count_d;

   logic               out_free;
   logic               accept;
   logic               full_line;
   logic [SW-1:0]      sum;
   logic [NUM_IN-1:0]  cnt_mask;
   logic [NUM_OUT-1:0] keep_mask;
   logic [LW-1:0]      masked;
   logic [LW-1:0]      merged;
   logic [LW-1:0]      spill;

   assign out_free     = !out_valid_q || bus.out_ready;
   assign bus.in_ready = (state_q == ST_FILL) && out_free;
   assign accept       = bus.in_valid && bus.in_ready;

   assign cnt_mask  = ~({NUM_IN{1'b1}} << bus.in_count);
   // Slots at or above the fill pointer belong to the current line; lower slots wrapped into spill.
   assign keep_mask = {NUM_OUT{1'b1}} << fill_q;
   assign sum       = SW'(fill_q) + SW'(bus.in_count);
   assign full_line = sum >= SW'(NUM_OUT);

   for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_slot
      logic [DATA_SIZE-1:0] rot_slot;

      if (gi < NUM_IN) begin : g_in
         assign masked[gi*DATA_SIZE +: DATA_SIZE] =
            cnt_mask[gi] ? bus.in_data[gi*DATA_SIZE +: DATA_SIZE] : '0;
      end else begin : g_pad
         assign masked[gi*DATA_SIZE +: DATA_SIZE] = '0;
      end

      // Left rotation by the fill pointer: entry i lands in slot (fill + i) mod NUM_OUT.
      always_comb begin
         rot_slot = '0;
         for (int p = 0; p < NUM_OUT; p++) begin
            if (fill_q == FW'(p)) begin
               rot_slot = masked[((gi - p + NUM_OUT) % NUM_OUT)*DATA_SIZE +: DATA_SIZE];
            end
         end
      end

      assign merged[gi*DATA_SIZE +: DATA_SIZE] =
         staging_q[gi*DATA_SIZE +: DATA_SIZE] | (keep_mask[gi] ? rot_slot : '0);
      assign spill[gi*DATA_SIZE +: DATA_SIZE]  = keep_mask[gi] ? '0 : rot_slot;
   end

   always_comb begin
      state_d     = state_q;
      fill_d      = fill_q;
      staging_d   = staging_q;
      out_valid_d = out_valid_q && !bus.out_ready;
      out_data_d  = out_data_q;
      out_count_d = out_count_q;
      case (state_q)
         ST_FILL: begin
            if (accept) begin
               if (full_line) begin
                  out_valid_d = 1'b1;
                  out_data_d  = merged;
                  out_count_d = COW'(NUM_OUT);
                  staging_d   = spill;
                  fill_d      = FW'(sum - SW'(NUM_OUT));
                  // Spill must go out as its own line before any new beat is taken.
                  if (bus.in_flush && (sum != SW'(NUM_OUT))) begin
                     state_d = ST_FLUSH_PEND;
                  end
               end else if (bus.in_flush && (sum != '0)) begin
                  out_valid_d = 1'b1;
                  out_data_d  = merged;
                  out_count_d = COW'(sum);
                  staging_d   = '0;
                  fill_d      = '0;
               end else begin
                  staging_d = merged;
                  fill_d    = FW'(sum);
               end
            end
         end
         ST_FLUSH_PEND: begin
            if (out_free) begin
               out_valid_d = 1'b1;
               out_data_d  = staging_q;
               out_count_d = COW'(fill_q);
               staging_d   = '0;
               fill_d      = '0;
               state_d     = ST_FILL;
            end
         end
         default: state_d = ST_FILL;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_FILL;
         fill_q      <= '0;
         staging_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_count_q <= '0;
      end else begin
         state_q     <= state_d;
         fill_q      <= fill_d;
         staging_q   <= staging_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_count_q <= out_count_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_count = out_count_q;

   a_count_legal: assert property (@(posedge clk) disable iff (!reset_n)
      bus.in_valid |-> (bus.in_count <= CIW'(NUM_IN)));

   a_beat_stable: assert property (@(posedge clk) disable iff (!reset_n)
      (bus.in_valid && !bus.in_ready) |=> (bus.in_valid && $stable(bus.in_data)
                                           && $stable(bus.in_count) && $stable(bus.in_flush)));
endmodule
